// File: rtl/display_scan_arbiter.sv
// -----------------------------------------------------------------------------
// display_scan_arbiter
//
// Shares one single-port 8-bit RAM between the CPU bus and an LED-matrix scan
// engine. The scanner fetches one framebuffer byte per row (FB_BASE + row),
// shows it for SCAN_DIV cycles and moves to the next row. The CPU wins
// arbitration by default. A starvation counter lets the scanner override the
// CPU once it has waited STARVE_MAX cycles without a grant.
//
// Optional feature (macro DISP_BLANK_EN):
//   defined   - when the dwell ends, the display moves to the next row with
//               every column off, until that row's data is captured.
//   undefined - the previous row stays lit until the new row's data is
//               captured. Then led_row and led_col change together.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   cpu_req    CPU access request, held until cpu_ack
//   cpu_we     CPU direction (1 = write, 0 = read)
//   cpu_addr   CPU address
//   cpu_wdata  CPU write data
//   cpu_rdata  CPU read data, valid while cpu_ack is high
//   cpu_ack    one-cycle completion pulse, the cycle after the grant
//   ram_addr   RAM address (combinational from the grant)
//   ram_we     RAM write enable
//   ram_oe     RAM output enable for reads
//   ram_wdata  RAM write data
//   ram_rdata  RAM registered read data (valid the cycle after the address)
//   led_row    one-hot, active-high row select
//   led_col    active-low column drive (inverted row data)
// -----------------------------------------------------------------------------
module display_scan_arbiter #(
    parameter logic [7:0]  FB_BASE    = 8'h00,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned SCAN_DIV   = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic       ram_oe,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] led_row,
    output logic [7:0] led_col
);

    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned WAIT_W  = $clog2(STARVE_MAX + 1);

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_DATA = 2'd1,
        DWELL      = 2'd2
    } scan_state_t;

    scan_state_t        state;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   row_next;
    logic [DWELL_W-1:0] dwell;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               ack_rd;

    logic               cand_cpu;
    logic               scan_grant;
    logic               cpu_grant;

    // Arbitration. The CPU is never a candidate in its own ack cycle.
    always_comb begin
        cand_cpu   = cpu_req & ~cpu_ack;
        scan_grant = 1'b0;
        cpu_grant  = 1'b0;
        if ((state == FETCH_REQ) && (!cand_cpu || (wait_cnt >= WAIT_MAX))) begin
            scan_grant = 1'b1;
        end else if (cand_cpu) begin
            cpu_grant = 1'b1;
        end
    end

    // RAM port drive for whichever side holds the grant this cycle.
    always_comb begin
        ram_addr  = 8'h00;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        ram_wdata = 8'h00;
        if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_oe    = ~cpu_we;
            ram_wdata = cpu_wdata;
        end else if (scan_grant) begin
            ram_addr  = FB_BASE + 8'(row);
            ram_oe    = 1'b1;
        end
    end

    // Row index after the current one, wrapping at ROWS-1.
    always_comb begin
        row_next = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end

    // The RAM read data arrives in the ack cycle, so it is passed straight
    // through and gated by the registered read-ack flag.
    assign cpu_rdata = ack_rd ? ram_rdata : 8'h00;

    // CPU handshake, starvation counter and scanner FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_REQ;
            row      <= '0;
            dwell    <= '0;
            wait_cnt <= '0;
            cpu_ack  <= 1'b0;
            ack_rd   <= 1'b0;
            led_row  <= 8'h01;
            led_col  <= 8'hFF;
        end else begin
            cpu_ack <= cpu_grant;
            ack_rd  <= cpu_grant & ~cpu_we;

            if (scan_grant) begin
                wait_cnt <= '0;
            end else if ((state == FETCH_REQ) && (wait_cnt < WAIT_MAX)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            case (state)
                FETCH_REQ: begin
                    if (scan_grant) begin
                        state <= FETCH_DATA;
                    end
                end
                FETCH_DATA: begin
                    led_col <= ~ram_rdata;
                    led_row <= 8'h01 << row;
                    dwell   <= '0;
                    state   <= DWELL;
                end
                DWELL: begin
                    if (dwell == DWELL_LAST) begin
                        row   <= row_next;
                        state <= FETCH_REQ;
`ifdef DISP_BLANK_EN
                        // Blank the next row until its data is captured.
                        led_col <= 8'hFF;
                        led_row <= 8'h01 << row_next;
`endif
                    end else begin
                        dwell <= dwell + DWELL_W'(1);
                    end
                end
                default: begin
                    state <= FETCH_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_scan_arbiter
//
// Self-checking bench for display_scan_arbiter with default parameters.
// It includes a RAM model with a registered read. A shadow copy of the
// framebuffer supplies the expected values. Expected display rows and CPU
// read data go into queues and are compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_display_scan_arbiter;

    localparam int unsigned PERIOD = 18;  // 1 fetch-req + 1 fetch-data + 16 dwell

    logic       clk;
    logic       reset;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic       ram_oe;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] led_row;
    logic [7:0] led_col;

    display_scan_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .led_row   (led_row),
        .led_col   (led_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int r);
        case (r)
            0:       pat = 8'h00;
            1:       pat = 8'h18;
            2:       pat = 8'h24;
            3:       pat = 8'h42;
            4:       pat = 8'h7E;
            5:       pat = 8'h42;
            6:       pat = 8'h42;
            default: pat = 8'h00;
        endcase
    endfunction

    // RAM model: write on the edge, registered read of the current address.
    logic [7:0] mem [256];
    logic [7:0] rdata_q;
    assign ram_rdata = rdata_q;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= pat(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rdata_q <= mem[ram_addr];
    end

    // Cycle index since reset release; cycle 0 is the first cycle out of reset.
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic       we;
        logic [7:0] data;
    } cpu_exp_t;

    cpu_exp_t    cpu_q [$];
    logic [15:0] disp_q [$];
    logic [7:0]  shadow [8];
    logic        scan_chk;

    // Monitor: CPU scoreboard always, scan schedule while scan_chk is set.
    always @(negedge clk) begin
        int r;
        int p;
        int row;
        int prv;
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        logic [15:0] e;
        cpu_exp_t ce;
        #1;
        if (!reset) begin
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                end else begin
                    ce = cpu_q.pop_front();
                    if (!ce.we) check("cpu_rdata", 32'(cpu_rdata), 32'(ce.data));
                end
            end
            if (scan_chk) begin
                r   = cyc / PERIOD;
                p   = cyc % PERIOD;
                row = r % 8;
                if (p == 0) begin
                    check("scan_addr", 32'(ram_addr), 32'(row));
                    check("scan_oe", 32'(ram_oe), 32'd1);
                    check("scan_we", 32'(ram_we), 32'd0);
                    exp_row = 8'h01 << row;
                    exp_col = ~shadow[row];
                    disp_q.push_back({exp_row, exp_col});
                end
                if (p == 1 && r > 0) begin
`ifdef DISP_BLANK_EN
                    exp_row = 8'h01 << row;
                    exp_col = 8'hFF;
`else
                    prv     = (r - 1) % 8;
                    exp_row = 8'h01 << prv;
                    exp_col = ~shadow[prv];
`endif
                    check("pre_capture_row", 32'(led_row), 32'(exp_row));
                    check("pre_capture_col", 32'(led_col), 32'(exp_col));
                end
                if (p == 10) begin
                    if (disp_q.size() == 0) begin
                        check("disp_q_underflow", 32'(disp_q.size()), 32'd1);
                    end else begin
                        e = disp_q.pop_front();
                        check("led_row", 32'(led_row), 32'(e[15:8]));
                        check("led_col", 32'(led_col), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        logic [7:0] bd;
        #20000;
        bd = 8'h00;
        $display("FAIL watchdog: cycle %0d, required end before %0d", cyc, 2000 + 32'(bd));
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ec;
        int exp_ack;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h00;
        cpu_wdata = 8'h00;
        scan_chk  = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = pat(i);

        // T1: reset for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_led_row", 32'(led_row), 32'h01);
        check("rst_led_col", 32'(led_col), 32'hFF);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        scan_chk = 1'b1;
        #1;
        check("t1_ram_addr", 32'(ram_addr), 32'h00);
        check("t1_ram_oe", 32'(ram_oe), 32'd1);

        // T2: idle CPU, nine row periods checked by the monitor.
        // T3: CPU write 03 <- 5A during the row-1 dwell.
        wait_until(9 * PERIOD + 5);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h03;
        cpu_wdata = 8'h5A;
        shadow[3] = 8'h5A;
        cpu_q.push_back('{we: 1'b1, data: 8'h5A});
        #1;
        check("t3_ram_we", 32'(ram_we), 32'd1);
        check("t3_ram_addr", 32'(ram_addr), 32'h03);
        check("t3_ram_wdata", 32'(ram_wdata), 32'h5A);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("t3_ack", 32'(cpu_ack), 32'd1);
        wait_until(11 * PERIOD + 10);
        #1;
        check("t3_row3_row", 32'(led_row), 32'h08);
        check("t3_row3_col", 32'(led_col), 32'hA5);

        // T4: CPU read of address 05 while the scanner dwells.
        wait_until(12 * PERIOD + 5);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h05;
        cpu_q.push_back('{we: 1'b0, data: shadow[5]});
        #1;
        check("t4_ram_addr", 32'(ram_addr), 32'h05);
        check("t4_ram_oe", 32'(ram_oe), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("t4_ack", 32'(cpu_ack), 32'd1);

        // T5: CPU holds its request over the row-6 fetch. The scanner takes
        // the CPU ack cycles, so all its phases shift by one cycle.
        wait_until(14 * PERIOD);
        scan_chk = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h05;
        for (int i = 0; i < 5; i++) cpu_q.push_back('{we: 1'b0, data: shadow[5]});
        #1;
        check("t5_c0_cpu_addr", 32'(ram_addr), 32'h05);
        check("t5_c0_cpu_oe", 32'(ram_oe), 32'd1);
        check("t5_c0_ack", 32'(cpu_ack), 32'd0);
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) cpu_req = 1'b0;
            #1;
            exp_ack = (i <= 9 && (i % 2) == 1) ? 1 : 0;
            check("t5_ack", 32'(cpu_ack), 32'(exp_ack));
            if (i == 1) begin
                check("t5_scan_addr", 32'(ram_addr), 32'h06);
                check("t5_scan_oe", 32'(ram_oe), 32'd1);
            end
            if (i == 2) begin
                check("t5_c2_cpu_addr", 32'(ram_addr), 32'h05);
`ifdef DISP_BLANK_EN
                check("t5_c2_row", 32'(led_row), 32'h40);
                check("t5_c2_col", 32'(led_col), 32'hFF);
`else
                ec = ~shadow[5];
                check("t5_c2_row", 32'(led_row), 32'h20);
                check("t5_c2_col", 32'(led_col), 32'(ec));
`endif
            end
            if (i == 3) begin
                ec = ~shadow[6];
                check("t5_c3_row", 32'(led_row), 32'h40);
                check("t5_c3_col", 32'(led_col), 32'(ec));
            end
            if (i == 19) begin
                check("t5_next_fetch_addr", 32'(ram_addr), 32'h07);
                check("t5_next_fetch_oe", 32'(ram_oe), 32'd1);
            end
        end

        // T6: reset lands on the edge right after a CPU grant.
        wait_until(14 * PERIOD + 22);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h80;
        cpu_wdata = 8'h77;
        reset     = 1'b1;
        #1;
        check("t6_grant_we", 32'(ram_we), 32'd1);
        check("t6_grant_addr", 32'(ram_addr), 32'h80);
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = pat(i);
        #1;
        check("t6_ack", 32'(cpu_ack), 32'd0);
        check("t6_led_row", 32'(led_row), 32'h01);
        check("t6_led_col", 32'(led_col), 32'hFF);
        check("t6_cpu_rdata", 32'(cpu_rdata), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("t6_ack_hold", 32'(cpu_ack), 32'd0);
        end
        @(negedge clk);
        reset    = 1'b0;
        scan_chk = 1'b1;
        #1;
        check("t6_post_addr", 32'(ram_addr), 32'h00);
        check("t6_post_oe", 32'(ram_oe), 32'd1);
        check("t6_post_we", 32'(ram_we), 32'd0);
        wait_until(2 * PERIOD);
        scan_chk = 1'b0;
        @(negedge clk);
        #1;
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("disp_q_pending", 32'(disp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
